// File: rtl/fork_join_ctrl.sv
// Fork/join launcher: one start request launches up to NCH timed channels and
// reports completion as join-all, join-any or join-none. Optional kill input under FORK_JOIN_KILL_EN.
module fork_join_ctrl #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*CW-1:0] dur,
`ifdef FORK_JOIN_KILL_EN
    input  logic              kill,
`endif
    output logic              ready,
    output logic              err,
    output logic              join_done,
    output logic [NCH-1:0]    ch_active,
    output logic [NCH-1:0]    ch_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ALL = 2'd1,
        WAIT_ANY = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ALL  = 2'd0;
    localparam logic [1:0] MODE_NONE = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NCH];
    logic [CW-1:0]   cnt_d [NCH];
    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  done_q, done_d;
    logic            join_q, join_d;
    logic            err_q, err_d;
    logic [NCH-1:0]  fin;
    logic [CW-1:0]   dur_i;
    logic            accept;
    logic            kill_w;

`ifdef FORK_JOIN_KILL_EN
    assign kill_w = kill;
`else
    assign kill_w = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_active[i] = (cnt_q[i] != '0);
        end
    end

    assign ready     = (state_q == IDLE);
    assign err       = err_q;
    assign join_done = join_q;
    assign ch_done   = done_q;
    assign accept    = start && ready && (mode != MODE_RSVD) && ((ch_en & ch_active) == '0);

    always_comb begin
        fin     = '0;
        dur_i   = '0;
        state_d = state_q;
        pend_d  = pend_q;
        join_d  = 1'b0;
        err_d   = start && !accept;

        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
                fin[i]   = (cnt_q[i] == CW'(1));
            end
            // A zero duration still runs for one cycle so every launch yields a ch_done.
            if (accept && ch_en[i]) begin
                dur_i    = dur[i*CW +: CW];
                cnt_d[i] = (dur_i == '0) ? CW'(1) : dur_i;
            end
        end
        done_d = fin;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((ch_en == '0) || (mode == MODE_NONE)) begin
                        join_d = 1'b1;
                    end else begin
                        pend_d  = ch_en;
                        state_d = (mode == MODE_ALL) ? WAIT_ALL : WAIT_ANY;
                    end
                end
            end
            WAIT_ALL: begin
                pend_d = pend_q & ~fin;
                if ((pend_q & ~fin) == '0) begin
                    join_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_ANY: begin
                if ((pend_q & fin) != '0) begin
                    join_d  = 1'b1;
                    pend_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Kill wins over everything, including a coincident start and any completion.
        if (kill_w) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_d[i] = '0;
            end
            done_d  = '0;
            join_d  = 1'b0;
            err_d   = 1'b0;
            pend_d  = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= '0;
            join_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            join_q  <= join_d;
            err_q   <= err_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: doc/fork_join_ctrl.md
# fork_join_ctrl

Hardware fork/join launcher: starts up to NCH concurrent timed channel "tasks" from one start request, then reports completion under a selectable join policy (join all, join any, join none). Generalises our fork/join study material into synthesizable form. Sits between a sequencing master (test sequencer or command decoder) and per-channel work engines that consume `ch_active`/`ch_done`.

## Interface
Parameters:
- NCH, 4, number of channels (1..16)
- CW, 8, duration counter width in bits

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch request, sampled every edge
- mode  input  2  join policy: 0 = ALL, 1 = ANY, 2 = NONE, 3 = reserved
- ch_en  input  NCH  channels to launch
- dur  input  NCH*CW  per-channel duration; channel i uses dur[i*CW +: CW]
- ready  output  1  controller can accept start
- err  output  1  one-cycle pulse: start rejected
- join_done  output  1  one-cycle pulse: join condition met
- ch_active  output  NCH  channel running
- ch_done  output  NCH  one-cycle pulse per channel completion
- kill  input  1  present only with FORK_JOIN_KILL_EN

## Operation
- FSM states: IDLE, WAIT_ALL, WAIT_ANY. `ready` = (state == IDLE).
- Accept: start && ready && mode != 3 && (ch_en & ch_active) == 0. Any other start while high → `err` pulse; nothing launched; no state change.
- On accept: each enabled channel loads its counter with max(dur_i, 1); `mode` is latched.
  - ch_en == 0: `join_done` pulse next cycle, stay IDLE, regardless of mode.
  - ALL → WAIT_ALL; ANY → WAIT_ANY; NONE → stay IDLE, `join_done` pulse next cycle.
- Channel: counter decrements each edge while active; the 1→0 transition clears `ch_active[i]` and pulses `ch_done[i]`.
- WAIT_ALL → IDLE when every channel launched by this start has completed; `join_done` pulses in the same cycle as the last `ch_done`.
- WAIT_ANY → IDLE on the first completion of a launched channel; `join_done` is coincident with that `ch_done`. Remaining channels keep running.
- Channels still running from an earlier NONE or ANY launch do not affect the current join condition. They only block relaunch of the same channel.
- Simultaneous completions: all corresponding `ch_done` bits pulse together, with a single `join_done`.

## Timing
- Reset (async assert; release synchronous to clk): state IDLE; counters 0; ready = 1; err, join_done, ch_active, ch_done = 0.
- Accept at edge E0:
  - `ch_active[i]` is high from E0 through E0+D (D = max(dur_i, 1) cycles).
  - `ch_done[i]` is high for one cycle after edge E0+D.
- NONE / empty-launch `join_done`: one cycle after E0.
- `err`: high the cycle after the offending edge.
- Back-to-back operation:
  - `ready` is high in the same cycle as `join_done`, so a start sampled at the next edge is accepted.
  - A channel whose `ch_done` is high is free for relaunch at the next edge.
- Reset mid-operation: all channels abort immediately. No `ch_done` or `join_done` pulses are generated.

## Configuration
- FORK_JOIN_KILL_EN defined:
  - `kill` port exists.
  - When kill is sampled high: all counters clear, `ch_active` goes to 0 next cycle, FSM returns to IDLE.
  - No `ch_done` or `join_done` for killed channels. `kill` has priority over a coincident start, which is dropped without `err`.
- Undefined: no `kill` port; channels always run to completion.

## Test plan
- ALL, NCH=4, ch_en=0011, dur0=20, dur1=30, start at E0 → ch_done[0] at E0+20, ch_done[1] and join_done at E0+30, ready high from E0+30.
- ANY, same stimulus → join_done with ch_done[0] at E0+20; ch_active[1] stays high until ch_done[1] at E0+30, with no second join_done.
- NONE: ch_en=0011, dur0=20, dur1=30 → join_done at E0+1. Then start ALL ch_en=0100, dur2=5 at E0+2 → ch_done[2] and join_done at E0+7. Channels 0/1 are still done at E0+20/E0+30.
- Conflict: NONE ch_en=0001, dur0=50. Then start ch_en=0001 at E0+3 → err at E0+4; ch_done[0] still at E0+50. Also: mode=3 → err; start while in WAIT_ALL → err.
- Boundaries:
  - ALL ch_en=1111, all dur=0 → all ch_done and join_done at E0+1.
  - ch_en=0000 → join_done at E0+1, no ch_active.
  - dur=255 (CW=8) → completes at E0+255.
- Reset/kill:
  - rst_n low at E0+10 of a 30-cycle ALL run → outputs at reset values, no pulses, start accepted after release.
  - With FORK_JOIN_KILL_EN: kill at E0+10 → ch_active = 0 at E0+11, ready = 1, no join_done.
